mem_arbiter: RTL and testbench

Two-port-to-one arbiter that shares a single unified instruction/data memory between the processor's instruction-fetch port and its load/store port. Sits between the ARM core and a unified memory: the fetch side drives PC, the data side drives ALUResult/WriteData/MemWrite, and the memory side drives the memory array. Provides per-requester ready handshakes, round-robin arbitration on conflict, and a programmable number of wait states so the core stalls until its access completes.

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------------------------------------------------------------------------
// Shares one unified instruction/data memory between the core's fetch port
// (i_*) and its load/store port (d_*). A winning request is latched and then
// presented to the memory for LATENCY+1 BUSY cycles. Completion is a one-cycle
// ready pulse in the final BUSY cycle. Stores write on the clock edge that ends
// that cycle. When both ports request together, the one that did not win last
// time gets the grant.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   i_req/i_addr        fetch request (held until i_ready) and address
//   i_rdata/i_ready     fetch data (valid with i_ready) and completion pulse
//   d_req/d_we/d_addr   load/store request (held until d_ready), 1=store, address
//   d_wdata             store data
//   d_rdata/d_ready     load data (valid with d_ready) and completion pulse
//   m_en/m_we           memory access in progress / write strobe
//   m_addr/m_wdata      memory address / write data
//   m_rdata             combinational memory read data for m_addr
//   busy                arbiter is in the BUSY state
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned LATENCY = 0,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic       OWN_I   = 1'b0;
  localparam logic       OWN_D   = 1'b1;
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  state_t        state, state_next;
  logic          owner, owner_next;
  logic          last_grant, last_grant_next;
  logic [3:0]    cnt, cnt_next;
  logic [AW-1:0] lat_addr, lat_addr_next;
  logic [DW-1:0] lat_wdata, lat_wdata_next;
  logic          lat_we, lat_we_next;
  logic          grant_d;

  // Read data is broadcast to both ports; only the ready pulse qualifies it.
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_grant <= OWN_I;
      cnt        <= 4'd0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_grant <= last_grant_next;
      cnt        <= cnt_next;
      lat_addr   <= lat_addr_next;
      lat_wdata  <= lat_wdata_next;
      lat_we     <= lat_we_next;
    end
  end

  // Next-state, grant and output decode.
  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_grant_next = last_grant;
    cnt_next        = cnt;
    lat_addr_next   = lat_addr;
    lat_wdata_next  = lat_wdata;
    lat_we_next     = lat_we;
    i_ready         = 1'b0;
    d_ready         = 1'b0;
    m_en            = 1'b0;
    m_we            = 1'b0;
    m_addr          = '0;
    m_wdata         = '0;
    busy            = 1'b0;
    // Data wins when alone, or on conflict when fetch had the last grant.
    grant_d         = d_req && (!i_req || (last_grant == OWN_I));

    // Outputs are forced to their idle values while reset is asserted, even
    // if the state register still holds BUSY (no ready, no write).
    if (!reset) begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state_next = BUSY;
            cnt_next   = LAT_CNT;
            if (grant_d) begin
              owner_next      = OWN_D;
              last_grant_next = OWN_D;
              lat_addr_next   = d_addr;
              lat_wdata_next  = d_wdata;
              lat_we_next     = d_we;
            end else begin
              owner_next      = OWN_I;
              last_grant_next = OWN_I;
              lat_addr_next   = i_addr;
              lat_wdata_next  = '0;
              lat_we_next     = 1'b0;
            end
          end else begin
            state_next = IDLE;
          end
        end
        BUSY: begin
          m_en    = 1'b1;
          busy    = 1'b1;
          m_addr  = lat_addr;
          m_wdata = lat_wdata;
          if (cnt != 4'd0) begin
            cnt_next = cnt - 4'd1;
          end else begin
            // Final cycle: single write strobe and the owner's ready pulse.
            m_we       = lat_we;
            state_next = IDLE;
            if (owner == OWN_D) begin
              d_ready = 1'b1;
            end else begin
              i_ready = 1'b1;
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end else begin
      state_next = IDLE;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: four instances with LATENCY 0..3, each with its
// own 256-word model memory (pre-filled with 0xA0000000|addr). Each instance
// has its own request lines, so an access on one instance leaves the others
// idle. A table of single transactions is followed by hand-written sequences
// for contention, reset during an access and a request dropped after grant.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          mem_init;
  logic [N-1:0]  i_req, d_req;
  logic          d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] i_rdata [N];
  logic [DW-1:0] d_rdata [N];
  logic [DW-1:0] m_wdata [N];
  logic [DW-1:0] m_rdata [N];
  logic [AW-1:0] m_addr  [N];
  logic [N-1:0]  i_ready, d_ready, m_en, m_we, busy;

  int compared = 0;
  int failed   = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [DW-1:0] mem [256];
    int viol = 0;

    mem_arbiter #(.LATENCY(g), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req[g]), .i_addr(i_addr), .i_rdata(i_rdata[g]), .i_ready(i_ready[g]),
      .d_req(d_req[g]), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata[g]), .d_ready(d_ready[g]),
      .m_en(m_en[g]), .m_we(m_we[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]),
      .m_rdata(m_rdata[g]), .busy(busy[g])
    );

    assign m_rdata[g] = mem[m_addr[g][7:0]];

    always @(posedge clk) begin
      if (mem_init) begin
        for (int a = 0; a < 256; a++) mem[a] <= 32'hA000_0000 | 32'(a);
      end else if (m_we[g]) begin
        mem[m_addr[g][7:0]] <= m_wdata[g];
      end
    end

    // Writes only with a ready pulse; never two readies at once.
    always @(negedge clk) begin
      if ((m_we[g] && !(i_ready[g] || d_ready[g])) || (i_ready[g] && d_ready[g]))
        viol <= viol + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          k;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          swap;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic do_access(input int k, input bit is_d, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input bit swap, output logic [31:0] rd, output int lat,
                           output int we_cnt, output int addr_bad, output int wrong,
                           output bit done);
    @(negedge clk);
    d_we    = we;
    d_wdata = wdata;
    if (is_d) begin
      d_addr   = addr;
      i_addr   = addr ^ 32'h80;
      d_req[k] = 1'b1;
    end else begin
      i_addr   = addr;
      d_addr   = addr ^ 32'h80;
      i_req[k] = 1'b1;
    end
    rd = '0; lat = 0; we_cnt = 0; addr_bad = 0; wrong = 0; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (swap && c == 1) begin
        d_addr  = addr + 32'h20;
        i_addr  = addr + 32'h20;
        d_wdata = ~wdata;
      end
      if (m_addr[k] !== addr) addr_bad++;
      if (m_we[k]) we_cnt++;
      if (is_d ? i_ready[k] : d_ready[k]) wrong++;
      if (is_d ? d_ready[k] : i_ready[k]) begin
        done     = 1'b1;
        lat      = c;
        rd       = is_d ? d_rdata[k] : i_rdata[k];
        i_req[k] = 1'b0;
        d_req[k] = 1'b0;
      end
    end
    i_req[k] = 1'b0;
    d_req[k] = 1'b0;
  endtask

  task automatic load(input int k, input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] rd; int lat, wc, ab, wr; bit done;
    do_access(k, 1'b1, 1'b0, addr, 32'h0, 1'b0, rd, lat, wc, ab, wr, done);
    chk(name, {done, rd}, {1'b1, exp});
  endtask

  initial begin
    logic [31:0] rd; int lat, wc, ab, wr; bit done;
    int pos [$]; bit who [$]; int both; int n_rdy; int rdy_at; int wcnt;
    logic [31:0] first_d;

    vecs[0] = '{0, 1'b0, 1'b0, 32'h08, 32'h0,    1'b0, 32'hA000_0008, 1};
    vecs[1] = '{2, 1'b1, 1'b1, 32'h64, 32'h7,    1'b0, 32'h0,         3};
    vecs[2] = '{2, 1'b1, 1'b0, 32'h64, 32'h0,    1'b0, 32'h7,         3};
    vecs[3] = '{1, 1'b1, 1'b0, 32'h10, 32'h0,    1'b0, 32'hA000_0010, 2};
    vecs[4] = '{3, 1'b0, 1'b0, 32'hFC, 32'h0,    1'b0, 32'hA000_00FC, 4};
    vecs[5] = '{1, 1'b1, 1'b1, 32'h20, 32'h1234, 1'b1, 32'h0,         2};
    vecs[6] = '{1, 1'b1, 1'b0, 32'h20, 32'h0,    1'b0, 32'h1234,      2};
    vecs[7] = '{1, 1'b1, 1'b0, 32'h40, 32'h0,    1'b0, 32'hA000_0040, 2};
    vecs[8] = '{0, 1'b1, 1'b1, 32'h00, 32'hDEAD, 1'b0, 32'h0,         1};
    vecs[9] = '{0, 1'b0, 1'b0, 32'h00, 32'h0,    1'b0, 32'hDEAD,      1};

    reset = 1'b1; mem_init = 1'b1;
    i_req = '0; d_req = '0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {i_ready, d_ready, m_en, m_we, busy}, 64'd0);
    chk("rst_data", {m_addr[0] | m_addr[1] | m_addr[2] | m_addr[3],
                     m_wdata[0] | m_wdata[1] | m_wdata[2] | m_wdata[3]}, 64'd0);
    reset = 1'b0; mem_init = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ctrl", {i_ready, d_ready, m_en, m_we, busy}, 64'd0);

    for (int v = 0; v < 10; v++) begin
      do_access(vecs[v].k, vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                vecs[v].swap, rd, lat, wc, ab, wr, done);
      chk($sformatf("v%0d_done", v), done, 1'b1);
      chk($sformatf("v%0d_lat", v), lat, vecs[v].exp_lat);
      chk($sformatf("v%0d_wecnt", v), wc, {31'd0, vecs[v].we});
      chk($sformatf("v%0d_maddr", v), ab, 0);
      chk($sformatf("v%0d_other_rdy", v), wr, 0);
      if (!vecs[v].we) chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rd);
      else chk($sformatf("v%0d_wdata", v), rd, vecs[v].exp_rd | rd);
      @(negedge clk);
      chk($sformatf("v%0d_busy_after", v), busy[vecs[v].k], 1'b0);
    end

    // Contention on LATENCY=1 after reset: D, I, D, I every 3 cycles.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    i_addr = 32'h08; d_addr = 32'h0C; d_we = 1'b0;
    i_req[1] = 1'b1; d_req[1] = 1'b1;
    both = 0; first_d = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (i_ready[1] && d_ready[1]) both++;
      if (d_ready[1] || i_ready[1]) begin
        if (pos.size() == 0) first_d = d_rdata[1];
        pos.push_back(n);
        who.push_back(d_ready[1]);
      end
    end
    i_req[1] = 1'b0; d_req[1] = 1'b0;
    chk("rr_count", pos.size(), 4);
    chk("rr_both", both, 0);
    chk("rr_first_rdata", first_d, 32'hA000_000C);
    for (int j = 0; j < 4; j++) begin
      if (j < pos.size()) begin
        chk($sformatf("rr%0d_pos", j), pos[j], 2 + 3 * j);
        chk($sformatf("rr%0d_owner", j), who[j], (j % 2 == 0));
      end
    end
    repeat (2) @(negedge clk);

    // Reset in the second BUSY cycle of a LATENCY=3 store.
    d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h55; d_req[3] = 1'b1;
    @(negedge clk);
    chk("rmid_started", m_en[3], 1'b1);
    @(negedge clk);
    reset = 1'b1; d_req[3] = 1'b0;
    #1;
    chk("rmid_outs", {m_en[3], busy[3], m_we[3], d_ready[3], i_ready[3]}, 64'd0);
    chk("rmid_bus", {m_addr[3], m_wdata[3]}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rmid_idle", busy[3], 1'b0);
    n_rdy = 0; wcnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (d_ready[3]) n_rdy++;
      if (m_we[3]) wcnt++;
    end
    chk("rmid_no_ready", n_rdy, 0);
    chk("rmid_no_write", wcnt, 0);
    load(3, 32'h30, 32'hA000_0030, "rmid_mem");

    // Request dropped right after grant, LATENCY=2 store.
    @(negedge clk);
    d_we = 1'b1; d_addr = 32'h70; d_wdata = 32'h99; d_req[2] = 1'b1;
    @(negedge clk);
    chk("drop_busy", busy[2], 1'b1);
    d_req[2] = 1'b0;
    n_rdy = 0; rdy_at = 0; wcnt = 0;
    for (int n = 2; n <= 8; n++) begin
      @(negedge clk);
      if (d_ready[2]) begin n_rdy++; rdy_at = n; end
      if (m_we[2]) wcnt++;
      if (n == 4) chk("drop_idle", busy[2], 1'b0);
    end
    chk("drop_ready_cnt", n_rdy, 1);
    chk("drop_ready_at", rdy_at, 3);
    chk("drop_we_cnt", wcnt, 1);
    chk("drop_still_idle", busy[2], 1'b0);
    load(2, 32'h70, 32'h99, "drop_mem");

    @(negedge clk);
    chk("monitor_viol", g_dut[0].viol + g_dut[1].viol + g_dut[2].viol + g_dut[3].viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
